recomplement: RTL and testbench

RECOMPLEMENT -- requirements
Module: recomplement

---
 rtl/recomplement_pkg.sv | 24 ++
 rtl/recomplement_if.sv | 48 ++++
 rtl/recomplement_lzc.sv | 26 ++
 rtl/recomplement.sv | 125 ++++++++++++
 tb/tb_recomplement.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/recomplement_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | recomplement_pkg                                                     |
// | Shared constants and the stage-1 payload type for recomplement.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package recomplement_pkg;

   localparam int DEFAULT_WIDTH = 50;
   localparam int MAX_WIDTH     = 64;
   localparam int LZC_W         = $clog2(DEFAULT_WIDTH + 1);

   function automatic int lzc_width(input int w);
      return $clog2(w + 1);
   endfunction

   // Sum is zero-extended to MAX_WIDTH so one type serves every WIDTH.
   typedef struct packed {
      logic [MAX_WIDTH-1:0] sum;
      logic                 sub;
   } stage_t;

endpackage
`default_nettype wire

// File: rtl/recomplement_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | recomplement_if                                                      |
// | Operand and result handshake bundle; out_lzc exists with             |
// | RECOMP_LZC_EN.                                                       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface recomplement_if
   import recomplement_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) ();
   localparam int LZCW = lzc_width(WIDTH);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_P;
   logic [WIDTH-1:0] in_C;
   logic             in_sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_mag;
   logic             out_sign;
   logic             out_zero;
   logic             out_ovf;
   logic             out_sub;
`ifdef RECOMP_LZC_EN
   logic [LZCW-1:0]  out_lzc;
`endif

   modport master (
      output in_valid, in_P, in_C, in_sub, out_ready,
      input  in_ready, out_valid, out_mag, out_sign, out_zero, out_ovf, out_sub
`ifdef RECOMP_LZC_EN
      , input out_lzc
`endif
   );

   modport slave (
      input  in_valid, in_P, in_C, in_sub, out_ready,
      output in_ready, out_valid, out_mag, out_sign, out_zero, out_ovf, out_sub
`ifdef RECOMP_LZC_EN
      , output out_lzc
`endif
   );

endinterface
`default_nettype wire

// File: rtl/recomplement_lzc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | recomplement_lzc                                                     |
// | Combinational leading-zero count; returns WIDTH for an all-zero word.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module recomplement_lzc #(
   parameter int WIDTH = 50,
   parameter int LZCW  = 6
) (
   input  logic [WIDTH-1:0] value,
   output logic [LZCW-1:0]  count
);

   // Ascending scan: the highest set bit is the last to write.
   always_comb begin
      count = LZCW'(WIDTH);
      for (int i = 0; i < WIDTH; i++) begin
         if (value[i]) begin
            count = LZCW'(WIDTH - 1 - i);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/recomplement.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | recomplement                                                         |
// | Two-stage carry-save resolve to sign/magnitude with ready/valid flow.|
// | Define RECOMP_LZC_EN to add the leading-zero count output.           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module recomplement
   import recomplement_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic           clk,
   input  logic           rst_n,
   recomplement_if.slave  bus
);
   localparam int               LZCW    = lzc_width(WIDTH);
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   logic             s1_vld_q, s1_vld_d;
   stage_t           s1_q, s1_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] mag_q, mag_d;
   logic             sign_q, sign_d;
   logic             zero_q, zero_d;
   logic             ovf_q, ovf_d;
   logic             sub_q, sub_d;
   logic             s2_load, s1_load;
   logic [WIDTH-1:0] sum_in, s1_sum, mag_next;

   assign s2_load      = !out_valid_q || bus.out_ready;
   assign s1_load      = !s1_vld_q || s2_load;
   assign bus.in_ready = s1_load;

   assign sum_in   = bus.in_P + bus.in_C;
   assign s1_sum   = s1_q.sum[WIDTH-1:0];
   assign mag_next = s1_sum[WIDTH-1] ? (~s1_sum) + WIDTH'(1) : s1_sum;

`ifdef RECOMP_LZC_EN
   logic [LZCW-1:0] lzc_q, lzc_d, lzc_next;

   recomplement_lzc #(.WIDTH(WIDTH), .LZCW(LZCW)) u_lzc (
      .value (mag_next),
      .count (lzc_next)
   );
`endif

   always_comb begin
      s1_vld_d = s1_vld_q;
      s1_d     = s1_q;
      if (s1_load) begin
         s1_vld_d = bus.in_valid;
         if (bus.in_valid) begin
            s1_d.sum = MAX_WIDTH'(sum_in);
            s1_d.sub = bus.in_sub;
         end
      end
   end

   // Zero/overflow compare the full zero-extended sum.
   always_comb begin
      out_valid_d = out_valid_q;
      mag_d       = mag_q;
      sign_d      = sign_q;
      zero_d      = zero_q;
      ovf_d       = ovf_q;
      sub_d       = sub_q;
`ifdef RECOMP_LZC_EN
      lzc_d       = lzc_q;
`endif
      if (s2_load) begin
         out_valid_d = s1_vld_q;
         if (s1_vld_q) begin
            mag_d  = mag_next;
            sign_d = s1_sum[WIDTH-1];
            zero_d = (s1_q.sum == '0);
            ovf_d  = (s1_q.sum == MAX_WIDTH'(MIN_NEG));
            sub_d  = s1_q.sub;
`ifdef RECOMP_LZC_EN
            lzc_d  = lzc_next;
`endif
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld_q    <= 1'b0;
         s1_q        <= '0;
         out_valid_q <= 1'b0;
         mag_q       <= '0;
         sign_q      <= 1'b0;
         zero_q      <= 1'b0;
         ovf_q       <= 1'b0;
         sub_q       <= 1'b0;
`ifdef RECOMP_LZC_EN
         lzc_q       <= '0;
`endif
      end else begin
         s1_vld_q    <= s1_vld_d;
         s1_q        <= s1_d;
         out_valid_q <= out_valid_d;
         mag_q       <= mag_d;
         sign_q      <= sign_d;
         zero_q      <= zero_d;
         ovf_q       <= ovf_d;
         sub_q       <= sub_d;
`ifdef RECOMP_LZC_EN
         lzc_q       <= lzc_d;
`endif
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_mag   = mag_q;
   assign bus.out_sign  = sign_q;
   assign bus.out_zero  = zero_q;
   assign bus.out_ovf   = ovf_q;
   assign bus.out_sub   = sub_q;
`ifdef RECOMP_LZC_EN
   assign bus.out_lzc   = lzc_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_recomplement.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_recomplement                                                      |
// | Directed and random stimulus against a signed-arithmetic model.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_recomplement;
   import recomplement_pkg::*;

   localparam int     W    = 50;
   localparam longint MOD  = 64'sd1 << W;
   localparam longint HALF = 64'sd1 << (W - 1);

   typedef struct {
      logic [W-1:0] mag;
      logic         sign;
      logic         zero;
      logic         ovf;
      logic         sub;
      int           lzc;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   recomplement_if #(.WIDTH(W)) bus ();
   recomplement #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   exp_t q[$];
   int   tests = 0;
   int   fails = 0;

   function automatic exp_t model(input logic [W-1:0] p, input logic [W-1:0] c, input logic s);
      exp_t   e;
      longint su, sv, m;
      su     = (longint'(p) + longint'(c)) % MOD;
      sv     = (su >= HALF) ? su - MOD : su;
      m      = (sv < 0) ? -sv : sv;
      e.sign = (sv < 0);
      e.zero = (sv == 0);
      e.ovf  = (sv == -HALF);
      e.mag  = W'(m);
      e.sub  = s;
      e.lzc  = W;
      for (int k = 0; k < W; k++)
         if (m >= (64'sd1 << k)) e.lzc = W - 1 - k;
      return e;
   endfunction

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      assert (act === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_valid"}, bus.out_valid, 0);
      chk({tag, "_mag"},   bus.out_mag,   0);
      chk({tag, "_flags"}, {bus.out_sign, bus.out_zero, bus.out_ovf, bus.out_sub}, 0);
`ifdef RECOMP_LZC_EN
      chk({tag, "_lzc"},   bus.out_lzc,   0);
`endif
   endtask

   // One clock cycle: drive, compare any presented result with the oldest expectation.
   task automatic cycle(input bit v, input logic [W-1:0] p, input logic [W-1:0] c,
                        input bit s, input bit ordy, output bit acc);
      exp_t e;
      @(negedge clk);
      bus.in_valid  = v;
      bus.in_P      = p;
      bus.in_C      = c;
      bus.in_sub    = s;
      bus.out_ready = ordy;
      #1;
      acc = v && bus.in_ready;
      if (bus.out_valid) begin
         if (q.size() == 0) begin
            chk("unexpected_out", 1, 0);
         end else begin
            e = q[0];
            chk("mag",  bus.out_mag, e.mag);
            chk("sign", bus.out_sign, e.sign);
            chk("zero", bus.out_zero, e.zero);
            chk("ovf",  bus.out_ovf, e.ovf);
            chk("sub",  bus.out_sub, e.sub);
`ifdef RECOMP_LZC_EN
            chk("lzc",  bus.out_lzc, 64'(e.lzc));
`endif
            if (ordy) void'(q.pop_front());
         end
      end
      if (acc) q.push_back(model(p, c, s));
   endtask

   task automatic idle(input int n);
      bit a;
      for (int i = 0; i < n; i++) cycle(0, '0, '0, 0, 1, a);
   endtask

   // Single operand into an empty pipe; result fields checked two cycles later.
   task automatic one(input string tag, input logic [W-1:0] p, input logic [W-1:0] c,
                      input logic [W-1:0] mag, input bit sign, input bit zero, input bit ovf);
      bit a;
      cycle(1, p, c, 1, 1, a);
      chk({tag, "_accept"}, a, 1);
      idle(1);
      chk({tag, "_lat1_valid"}, bus.out_valid, 0);
      idle(1);
      chk({tag, "_lat2_valid"}, bus.out_valid, 1);
      chk({tag, "_mag"},  bus.out_mag, mag);
      chk({tag, "_flags"}, {bus.out_sign, bus.out_zero, bus.out_ovf}, {sign, zero, ovf});
   endtask

   logic [W-1:0] ops[4];
   logic [W-1:0] rp, rc;
   bit           acc;
   int           n;

   initial begin
      bus.in_valid  = 0;
      bus.in_P      = '0;
      bus.in_C      = '0;
      bus.in_sub    = 0;
      bus.out_ready = 0;

      repeat (3) @(negedge clk);
      #1;
      check_reset_outputs("rst");
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_release_in_ready", bus.in_ready, 1);

      one("pos",  W'(5), W'(3), W'(8), 0, 0, 0);
      one("neg",  W'(MOD - 10), W'(3), W'(7), 1, 0, 0);
      one("zero", W'(MOD - 1), W'(1), W'(0), 0, 1, 0);
      one("ovf",  W'(HALF), W'(0), W'(HALF), 1, 0, 1);
      idle(1);
`ifdef RECOMP_LZC_EN
      one("lzc1", W'(1), W'(0), W'(1), 0, 0, 0);
      chk("lzc_one", bus.out_lzc, 49);
      one("lzc0", W'(0), W'(0), W'(0), 0, 1, 0);
      chk("lzc_zero", bus.out_lzc, 50);
      idle(1);
`endif
      chk("directed_drained", q.size(), 0);

      // Backpressure: four operands, downstream stalled for three cycles.
      for (int i = 0; i < 4; i++) ops[i] = W'({$urandom, $urandom});
      n = 0;
      for (int i = 0; i < 3; i++) begin
         cycle(1, ops[n], ~ops[n], 0, 0, acc);
         if (acc) n++;
      end
      chk("bp_accepts", n, 2);
      chk("bp_in_ready_low", bus.in_ready, 0);
      for (int i = 0; i < 20 && n < 4; i++) begin
         cycle(1, ops[n], ~ops[n], 0, 1, acc);
         if (acc) n++;
      end
      chk("bp_all_accepted", n, 4);
      idle(4);
      chk("bp_drained", q.size(), 0);

      // Random traffic with random backpressure and corner operands.
      for (int i = 0; i < 400; i++) begin
         rp = W'({$urandom, $urandom});
         case ($urandom_range(0, 7))
            0:       rc = W'(MOD - longint'(rp));
            1:       begin rp = W'(HALF); rc = '0; end
            2:       rc = W'($urandom_range(0, 3));
            default: rc = W'({$urandom, $urandom});
         endcase
         cycle($urandom_range(0, 3) != 0, rp, rc, 1'($urandom), $urandom_range(0, 3) != 0, acc);
      end
      for (int i = 0; i < 20 && q.size() != 0; i++) idle(1);
      chk("random_drained", q.size(), 0);

      // Reset with both stages full.
      for (int i = 0; i < 3; i++) cycle(1, W'(i + 11), W'(7), 1, 0, acc);
      chk("mid_full_valid", bus.out_valid, 1);
      @(negedge clk);
      rst_n         = 1'b0;
      bus.in_valid  = 0;
      #1;
      check_reset_outputs("mid_rst");
      q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("mid_release_in_ready", bus.in_ready, 1);
      idle(5);
      chk("mid_no_stale", bus.out_valid, 0);
      one("post_rst", W'(20), W'(MOD - 25), W'(5), 1, 0, 0);
      idle(2);
      chk("final_drained", q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
